// File: rtl/zigbee_tx_pkg.sv
// Shared transmit-side definitions for the ZigBee chip serializer: default
// geometry, the minimum samples-per-chip and the serializer FSM states.
package zigbee_tx_pkg;

  localparam int NB_P_W   = 6;
  localparam int CHIPS    = 32;
  localparam int NB_P_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tx_chip_serializer_if.sv
// Symbol-feed handshake bundle between a symbol source and tx_chip_serializer.
interface tx_chip_serializer_if #(
  parameter int NB_P_W = zigbee_tx_pkg::NB_P_W,
  parameter int CHIPS  = zigbee_tx_pkg::CHIPS
);
  logic [NB_P_W-1:0] nb_p;
  logic [CHIPS-1:0]  sym_chips;
  logic              sym_valid;
  logic              sym_ready;
  logic              frame_active;

  modport master (
    output nb_p, sym_chips, sym_valid, frame_active,
    input  sym_ready
  );

  modport slave (
    input  nb_p, sym_chips, sym_valid, frame_active,
    output sym_ready
  );
endinterface

// File: rtl/tx_sample_counter.sv
// Per-chip sample counter: latches (clamped) samples-per-chip on load and
// issues registered chip-start and mid-chip strobes, mirroring the RX decision counter.
module tx_sample_counter #(
  parameter int NB_P_W = zigbee_tx_pkg::NB_P_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_stop,
  input  logic [NB_P_W-1:0] i_nb_p,
  output logic              o_last,
  output logic              o_chip_en,
  output logic              o_mid_en
);
  import zigbee_tx_pkg::*;

  localparam logic [NB_P_W-1:0] ONE     = NB_P_W'(1);
  localparam logic [NB_P_W-1:0] NB_MIN  = NB_P_W'(NB_P_MIN);

  logic [NB_P_W-1:0] nb_q, mid_q, cnt;
  logic [NB_P_W-1:0] nb_eff, mid_eff, cnt_nxt;
  logic              active;

  always_comb begin
    nb_eff  = (i_nb_p < NB_MIN) ? NB_MIN : i_nb_p;
    mid_eff = (nb_eff - ONE) >> 1;
    cnt_nxt = o_last ? '0 : cnt + ONE;
  end

  assign o_last = active && (cnt == nb_q - ONE);

  // Strobes are registered from the next count so they line up with the
  // rail update made on the same edge in the parent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nb_q      <= NB_MIN;
      mid_q     <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      o_chip_en <= 1'b0;
      o_mid_en  <= 1'b0;
    end else if (i_load) begin
      nb_q      <= nb_eff;
      mid_q     <= mid_eff;
      cnt       <= '0;
      active    <= 1'b1;
      o_chip_en <= 1'b1;
      o_mid_en  <= (mid_eff == '0);
    end else if (i_stop) begin
      cnt       <= '0;
      active    <= 1'b0;
      o_chip_en <= 1'b0;
      o_mid_en  <= 1'b0;
    end else if (active) begin
      cnt       <= cnt_nxt;
      o_chip_en <= (cnt_nxt == '0);
      o_mid_en  <= (cnt_nxt == mid_q);
    end else begin
      o_chip_en <= 1'b0;
      o_mid_en  <= 1'b0;
    end
  end
endmodule

// File: rtl/tx_chip_serializer.sv
// O-QPSK chip serializer: takes CHIPS-bit PN symbols and emits offset I/Q chip
// levels, one chip per nb_P samples. Define TX_UNDERRUN_CNT_EN for the underrun counter.
module tx_chip_serializer #(
  parameter int NB_P_W = zigbee_tx_pkg::NB_P_W,
  parameter int CHIPS  = zigbee_tx_pkg::CHIPS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_P_W-1:0] i_nb_P,
  input  logic [CHIPS-1:0]  i_sym_chips,
  input  logic              i_sym_valid,
  output logic              o_sym_ready,
  input  logic              i_frame_active,
  output logic              o_chip_i,
  output logic              o_chip_q,
  output logic              o_chip_en,
  output logic              o_mid_en,
  output logic              o_busy,
  output logic              o_underrun,
  output logic [15:0]       o_underrun_cnt
);
  import zigbee_tx_pkg::*;

  localparam int                CIDX_W   = (CHIPS > 1) ? $clog2(CHIPS) : 1;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(CHIPS - 1);

  state_t            state;
  logic [CHIPS-1:0]  chips_q;
  logic [CIDX_W-1:0] chip_idx, idx_nxt;
  logic              last_sample, end_sym, xfer, stop;

  tx_sample_counter #(.NB_P_W(NB_P_W)) u_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (xfer),
    .i_stop    (stop),
    .i_nb_p    (i_nb_P),
    .o_last    (last_sample),
    .o_chip_en (o_chip_en),
    .o_mid_en  (o_mid_en)
  );

  assign end_sym     = (state == RUN) && last_sample && (chip_idx == LAST_IDX);
  assign o_sym_ready = (state == IDLE) || end_sym;
  assign xfer        = i_sym_valid && o_sym_ready;
  assign stop        = end_sym && !xfer;
  assign o_underrun  = stop && i_frame_active;
  assign o_busy      = (state == RUN);
  assign idx_nxt     = chip_idx + CIDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      chips_q  <= '0;
      chip_idx <= '0;
      o_chip_i <= 1'b0;
      o_chip_q <= 1'b0;
    end else if (xfer) begin
      state    <= RUN;
      chips_q  <= i_sym_chips;
      chip_idx <= '0;
      o_chip_i <= i_sym_chips[0];
    end else if (state == RUN && last_sample) begin
      if (end_sym) begin
        state <= IDLE;
      end else begin
        chip_idx <= idx_nxt;
        // Even chips ride I, odd chips ride Q; the idle rail holds for the offset.
        if (!idx_nxt[0]) o_chip_i <= chips_q[idx_nxt];
        else             o_chip_q <= chips_q[idx_nxt];
      end
    end
  end

`ifdef TX_UNDERRUN_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  o_underrun_cnt <= '0;
    else if (o_underrun && o_underrun_cnt != 16'hFFFF) o_underrun_cnt <= o_underrun_cnt + 16'd1;
  end
`else
  assign o_underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_tx_chip_serializer.sv
// Directed bench for tx_chip_serializer: timing, back-to-back, clamp, underrun,
// mid-symbol reset and mid-symbol nb_P change.
module tb_tx_chip_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        chip_i, chip_q, chip_en, mid_en, busy, underrun;
  logic [15:0] underrun_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  tx_chip_serializer_if #(.NB_P_W(6), .CHIPS(32)) bus ();

  tx_chip_serializer #(.NB_P_W(6), .CHIPS(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_nb_P         (bus.nb_p),
    .i_sym_chips    (bus.sym_chips),
    .i_sym_valid    (bus.sym_valid),
    .o_sym_ready    (bus.sym_ready),
    .i_frame_active (bus.frame_active),
    .o_chip_i       (chip_i),
    .o_chip_q       (chip_q),
    .o_chip_en      (chip_en),
    .o_mid_en       (mid_en),
    .o_busy         (busy),
    .o_underrun     (underrun),
    .o_underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Drive one transfer from IDLE; returns #1 after the transfer edge (cycle 0).
  task automatic load(input logic [31:0] ch, input logic [5:0] nb);
    @(negedge clk);
    bus.sym_chips = ch;
    bus.nb_p      = nb;
    bus.sym_valid = 1'b1;
    check("load_ready", {31'd0, bus.sym_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
  endtask

  // Watch ncyc cycles starting at cycle 0 (just after a load) against an
  // expected chip period and mid-chip offset.
  task automatic watch(input int ncyc, input int period, input int mid,
                       input int chg_cyc, input logic [5:0] chg_nb, input int cap_cyc,
                       output int en_err, output int en_cnt, output int mid_err,
                       output int rdy_cnt, output int ur_cnt, output int ur_at,
                       output logic cap_i, output logic cap_q);
    en_err = 0; en_cnt = 0; mid_err = 0; rdy_cnt = 0; ur_cnt = 0; ur_at = -1;
    cap_i = 1'bx; cap_q = 1'bx;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc == chg_cyc) bus.nb_p = chg_nb;
      if (chip_en !== ((cyc % period) == 0)) en_err++;
      if (mid_en !== ((cyc % period) == mid)) mid_err++;
      if (chip_en === 1'b1) en_cnt++;
      if (bus.sym_ready === 1'b1) rdy_cnt++;
      if (underrun === 1'b1) begin ur_cnt++; ur_at = cyc; end
      if (cyc == cap_cyc) begin cap_i = chip_i; cap_q = chip_q; end
      @(posedge clk);
      #1;
    end
  endtask

  int   en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, xfers, last_en, gap_err;
  logic ci, cq;

  initial begin
    rst = 1'b1;
    bus.nb_p = 6'd4; bus.sym_chips = '0; bus.sym_valid = 1'b0; bus.frame_active = 1'b0;
    #23;
    check("rst_outputs", {25'd0, chip_i, chip_q, chip_en, mid_en, busy, underrun, bus.sym_ready}, 32'h1);
    check("rst_urun_cnt", {16'd0, underrun_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single symbol, nb_P=4
    load(32'hAAAA_AAAA, 6'd4);
    watch(128, 4, 1, -1, 6'd0, 4, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    check("t1_en_pattern", en_err, 0);
    check("t1_en_count", en_cnt, 32);
    check("t1_mid_pattern", mid_err, 0);
    check("t1_rails_chip1", {30'd0, ci, cq}, 32'b01);
    check("t1_ready_in_run", rdy_cnt, 1);
    check("t1_no_underrun", ur_cnt, 0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_rails", {30'd0, chip_i, chip_q}, 32'b01);

    // Back-to-back symbols, nb_P=5, valid held high
    @(negedge clk);
    bus.sym_chips = 32'hAAAA_AAAA; bus.nb_p = 6'd5; bus.sym_valid = 1'b1;
    xfers = 0; en_cnt = 0; gap_err = 0; last_en = -1;
    for (int cyc = 0; cyc < 340; cyc++) begin
      if (bus.sym_ready && bus.sym_valid) xfers++;
      if (chip_en) begin
        if (last_en >= 0 && cyc - last_en != 5) gap_err++;
        last_en = cyc;
        en_cnt++;
      end
      @(posedge clk);
      #1;
      if (xfers == 1) bus.sym_chips = 32'h4000_0000;
      if (xfers == 2) bus.sym_valid = 1'b0;
      @(negedge clk);
    end
    check("t2_transfers", xfers, 2);
    check("t2_en_count", en_cnt, 64);
    check("t2_en_spacing", gap_err, 0);
    check("t2_final_rails", {30'd0, chip_i, chip_q}, 32'b10);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Clamping: nb_P=0 and nb_P=1 both run at 2 samples per chip
    for (int k = 0; k < 2; k++) begin
      load(32'h1234_5678, 6'(k));
      watch(64, 2, 0, -1, 6'd0, -1, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
      check($sformatf("t3_nb%0d_en_pattern", k), en_err, 0);
      check($sformatf("t3_nb%0d_mid_pattern", k), mid_err, 0);
      check($sformatf("t3_nb%0d_en_count", k), en_cnt, 32);
    end
    check("t3_idle", {31'd0, busy}, 32'd0);

    // Underrun: frame active, single symbol, nb_P=3
    check("t4_cnt_before", {16'd0, underrun_cnt}, 32'd0);
    bus.frame_active = 1'b1;
    load(32'h0F0F_0F0F, 6'd3);
    watch(96, 3, 1, -1, 6'd0, -1, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    bus.frame_active = 1'b0;
    check("t4_urun_pulses", ur_cnt, 1);
    check("t4_urun_cycle", ur_at, 95);
    check("t4_en_pattern", en_err, 0);
`ifdef TX_UNDERRUN_CNT_EN
    check("t4_urun_cnt", {16'd0, underrun_cnt}, 32'd1);
`else
    check("t4_urun_cnt", {16'd0, underrun_cnt}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("t4_urun_quiet", {31'd0, underrun}, 32'd0);

    // Reset at chip 10, then a fresh nb_P=3 symbol from chip 0
    load(32'hFFFF_FFFF, 6'd4);
    watch(40, 4, 1, -1, 6'd0, 39, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    check("t5_pre_rails", {30'd0, ci, cq}, 32'b11);
    rst = 1'b1;
    #1;
    check("t5_rst_outputs", {26'd0, chip_i, chip_q, chip_en, mid_en, busy, underrun}, 32'd0);
    check("t5_rst_urun_cnt", {16'd0, underrun_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load(32'h0000_0001, 6'd3);
    watch(96, 3, 1, -1, 6'd0, 0, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    check("t5_chip0_rails", {30'd0, ci, cq}, 32'b10);
    check("t5_en_pattern", en_err, 0);
    check("t5_en_count", en_cnt, 32);
    check("t5_final_rails", {30'd0, chip_i, chip_q}, 32'b00);

    // nb_P change 4->8 at chip 5 is ignored until the next load
    load(32'hAAAA_AAAA, 6'd4);
    watch(128, 4, 1, 20, 6'd8, -1, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    check("t6_period_kept", en_err, 0);
    check("t6_count_kept", en_cnt, 32);
    load(32'hAAAA_AAAA, 6'd8);
    watch(256, 8, 3, -1, 6'd0, -1, en_err, en_cnt, mid_err, rdy_cnt, ur_cnt, ur_at, ci, cq);
    check("t6_new_period", en_err, 0);
    check("t6_new_mid", mid_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tx_chip_serializer.md
TX_CHIP_SERIALIZER -- requirements
Module: tx_chip_serializer

Interface
REQ-001 SHALL have parameter NB_P_W, default 6: width of the samples-per-chip input.
REQ-002 SHALL have parameter CHIPS, default 32: chips per symbol (PN sequence length).
REQ-003 SHALL have port i_clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_nb_P  in  NB_P_W  samples per chip.
REQ-006 SHALL have port i_sym_chips  in  CHIPS  PN chip word; bit 0 is transmitted first.
REQ-007 SHALL have port i_sym_valid  in  1  i_sym_chips is valid.
REQ-008 SHALL have port o_sym_ready  out  1  the block accepts a symbol this cycle.
REQ-009 SHALL have port i_frame_active  in  1  a frame is in progress; qualifies underrun.
REQ-010 SHALL have port o_chip_i / o_chip_q  out  1 each  O-QPSK I and Q chip levels.
REQ-011 SHALL have port o_chip_en  out  1  one-cycle strobe on the first sample of each chip.
REQ-012 SHALL have port o_mid_en  out  1  one-cycle strobe at mid-chip, the transmit-side mirror of the receiver decision point.
REQ-013 SHALL have port o_busy  out  1  high while in RUN.
REQ-014 SHALL have port o_underrun  out  1  one-cycle strobe on an underrun.
REQ-015 SHALL have port o_underrun_cnt  out  16  underrun count.

Function
REQ-016 SHALL have an FSM with states IDLE and RUN.
REQ-017 SHALL transfer a symbol on any cycle where i_sym_valid && o_sym_ready.
REQ-018 SHALL drive o_sym_ready high in IDLE, and in RUN only on the last sample of chip CHIPS-1.
REQ-019 SHALL, on a transfer, latch i_sym_chips and i_nb_P, clear the sample counter and chip index, and enter or stay in RUN.
  - Output takes effect the next cycle: 1-cycle latency from transfer to the first o_chip_en.
REQ-020 SHALL clamp a latched nb_P below 2 to 2.
  - i_nb_P changes are ignored until the next symbol load.
REQ-021 SHALL use a sample counter running 0..nb_P-1.
  - On wrap, the chip index increments; it runs 0..CHIPS-1.
REQ-022 SHALL assert o_chip_en when the sample counter = 0.
REQ-023 SHALL assert o_mid_en when the sample counter = (nb_P-1)>>1, computed at NB_P_W bits.
REQ-024 SHALL, on o_chip_en, load the chip into o_chip_i if the chip index is even, else into o_chip_q.
  - The other rail holds its value, giving the one-chip I/Q offset.
REQ-025 SHALL, on the last sample of the last chip with a transfer, load the next symbol with no gap (back-to-back symbols).
REQ-026 SHALL, on the last sample of the last chip with no transfer, return to IDLE.
  - If i_frame_active=1 at that cycle, it pulses o_underrun.
  - o_chip_i/o_chip_q hold their last values in IDLE.
REQ-027 SHALL ignore i_sym_valid while o_sym_ready=0; the symbol is not consumed.

Reset
REQ-028 SHALL, on i_rst=1, asynchronously force the following:
  - FSM to IDLE.
  - Counters, o_chip_i, o_chip_q, o_chip_en, o_mid_en, o_busy, o_underrun and o_underrun_cnt to 0.
REQ-029 SHALL, on reset mid-symbol, discard the remaining chips; the first post-reset transfer starts at chip 0.

Configuration
REQ-030 SHALL, with TX_UNDERRUN_CNT_EN defined, increment o_underrun_cnt on each o_underrun, saturating at 0xFFFF.
REQ-031 SHALL, without TX_UNDERRUN_CNT_EN, tie o_underrun_cnt to 0 and implement no counter flops.
  - o_underrun is always present.

Structure
REQ-032 SHALL place NB_P_W, CHIPS, NB_P_MIN=2 and the IDLE/RUN state enum in shared package zigbee_tx_pkg.
REQ-033 SHALL implement the sample counter plus the chip and mid strobes as sub-module tx_sample_counter.
  - It is the transmit counterpart of the receiver decision counter.

Verification
REQ-034 SHALL cover the single-symbol timing case:
  - Stimulus: nb_P=4, chips=0xAAAAAAAA, one transfer.
  - Response: o_chip_en every 4 cycles, 32 pulses; o_mid_en 1 cycle after each o_chip_en.
  - Response: o_chip_i=0 and o_chip_q=1 after chips 0 and 1; then IDLE with o_busy=0.
REQ-035 SHALL cover back-to-back symbols:
  - Stimulus: i_sym_valid held high with 2 symbols, nb_P=5.
  - Response: 64 o_chip_en pulses evenly spaced 5 cycles apart; o_sym_ready high exactly twice.
REQ-036 SHALL cover clamping:
  - Stimulus: nb_P=0 and nb_P=1.
  - Response: chip period is 2 cycles; o_mid_en coincides with o_chip_en.
REQ-037 SHALL cover underrun:
  - Stimulus: i_frame_active=1, one symbol, then no valid.
  - Response: o_underrun pulses once at chip 31 sample nb_P-1; o_underrun_cnt=1 with TX_UNDERRUN_CNT_EN, 0 without.
REQ-038 SHALL cover reset mid-symbol:
  - Stimulus: i_rst asserted at chip 10, then a new symbol with nb_P=3.
  - Response: all outputs 0 immediately; new symbol begins at chip 0.
REQ-039 SHALL cover a mid-symbol configuration change:
  - Stimulus: i_nb_P changed from 4 to 8 at chip 5.
  - Response: chip period stays 4 until the next symbol load.
